// File: rtl/ntm_matrix_transpose.sv
// Streaming matrix transpose: buffers a SIZE_I x SIZE_J matrix received row-major,
// then emits its SIZE_J x SIZE_I transpose row-major over a valid/ready stream.
module ntm_matrix_transpose #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned SIZE_I    = 4,
  parameter int unsigned SIZE_J    = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [DATA_SIZE-1:0]                           in_data,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [DATA_SIZE-1:0]                           out_data,
  output logic [(SIZE_J > 1 ? $clog2(SIZE_J) : 1)-1:0]   out_i,
  output logic [(SIZE_I > 1 ? $clog2(SIZE_I) : 1)-1:0]   out_j,
  output logic                                           out_last,
  output logic                                           busy,
  output logic                                           done
);

  // IW indexes the SIZE_I dimension, JW the SIZE_J dimension.
  localparam int unsigned IW = (SIZE_I > 1) ? $clog2(SIZE_I) : 1;
  localparam int unsigned JW = (SIZE_J > 1) ? $clog2(SIZE_J) : 1;
  localparam logic [IW-1:0] IMAX = IW'(SIZE_I - 1);
  localparam logic [JW-1:0] JMAX = JW'(SIZE_J - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StEmit} state_e;

  state_e                 state_q;
  logic [IW-1:0]          ii_q;
  logic [JW-1:0]          jj_q;
  logic [JW-1:0]          oi_q;
  logic [IW-1:0]          oj_q;
  logic [DATA_SIZE-1:0]   mem [SIZE_I][SIZE_J];
  logic                   load_en;

  assign load_en = in_valid && in_ready;

  // Storage is intentionally not reset; every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[ii_q][jj_q] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ii_q      <= '0;
      jj_q      <= '0;
      oi_q      <= '0;
      oj_q      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_i     <= '0;
      out_j     <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StLoad;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            ii_q     <= '0;
            jj_q     <= '0;
            oi_q     <= '0;
            oj_q     <= '0;
          end
        end
        StLoad: begin
          if (load_en) begin
            if (jj_q == JMAX) begin
              jj_q <= '0;
              if (ii_q == IMAX) begin
                ii_q     <= '0;
                in_ready <= 1'b0;
                state_q  <= StEmit;
              end else begin
                ii_q <= ii_q + IW'(1);
              end
            end else begin
              jj_q <= jj_q + JW'(1);
            end
          end
        end
        StEmit: begin
          // Output register is empty or being drained this edge.
          if (!out_valid || out_ready) begin
            if (out_valid && out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state_q   <= StIdle;
            end else begin
              out_valid <= 1'b1;
              out_data  <= mem[oj_q][oi_q];
              out_i     <= oi_q;
              out_j     <= oj_q;
              out_last  <= (oi_q == JMAX) && (oj_q == IMAX);
              if (oj_q == IMAX) begin
                oj_q <= '0;
                oi_q <= (oi_q == JMAX) ? '0 : oi_q + JW'(1);
              end else begin
                oj_q <= oj_q + IW'(1);
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ntm_matrix_transpose.sv
// Self-checking bench for ntm_matrix_transpose: 4x4, 2x3 and 1x1 instances checked
// against a transpose computed directly from the loaded matrix.
module tb_ntm_matrix_transpose;

  typedef logic [7:0] mat_t [4][4];

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // 4x4 instance
  logic       a_start, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic       a_busy, a_done;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_out_i, a_out_j;

  ntm_matrix_transpose #(.DATA_SIZE(8), .SIZE_I(4), .SIZE_J(4)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_i(a_out_i), .out_j(a_out_j), .out_last(a_out_last),
    .busy(a_busy), .done(a_done)
  );

  // 2x3 instance
  logic       b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic       b_busy, b_done;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_out_i;
  logic [0:0] b_out_j;

  ntm_matrix_transpose #(.DATA_SIZE(8), .SIZE_I(2), .SIZE_J(3)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_i(b_out_i), .out_j(b_out_j), .out_last(b_out_last),
    .busy(b_busy), .done(b_done)
  );

  // 1x1 instance
  logic       c_start, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last;
  logic       c_busy, c_done;
  logic [7:0] c_in_data, c_out_data;
  logic [0:0] c_out_i, c_out_j;

  ntm_matrix_transpose #(.DATA_SIZE(8), .SIZE_I(1), .SIZE_J(1)) dut_c (
    .clk(clk), .rst(rst), .start(c_start), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_i(c_out_i), .out_j(c_out_j), .out_last(c_out_last),
    .busy(c_busy), .done(c_done)
  );

  task automatic check_a_reset(input string tag);
    check(tag, 32'({a_in_ready, a_out_valid, a_out_last, a_busy, a_done, a_out_i, a_out_j,
                    a_out_data}), 0);
  endtask

  task automatic start_a();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check("a_start_ready", 32'(a_in_ready), 1);
    check("a_start_busy", 32'(a_busy), 1);
  endtask

  // Streams m row-major; returns early once abort_after elements are accepted.
  task automatic load_a(input mat_t m, input bit gaps, input int abort_after);
    int k = 0;
    int guard = 0;
    while (k < 16 && guard < 1000) begin
      if (abort_after >= 0 && k == abort_after) return;
      a_in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      a_in_data  = m[k / 4][k % 4];
      if (a_in_valid && a_in_ready) k++;
      @(negedge clk);
      guard++;
    end
    a_in_valid = 1'b0;
    check("a_load_count", 32'(k), 16);
    check("a_load_ready_drop", 32'(a_in_ready), 0);
  endtask

  // bp: 0 always ready, 1 pattern 1-0-0-1, 2 random.
  task automatic emit_a(input mat_t m, input int bp, input bit junk, input int start_at,
                        input bit restart);
    int k = 0;
    int cyc = 0;
    while (k < 16 && cyc < 500) begin
      case (bp)
        0:       a_out_ready = 1'b1;
        1:       a_out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: a_out_ready = 1'($urandom_range(0, 1));
      endcase
      if (junk) begin
        a_in_valid = 1'b1;
        a_in_data  = 8'hFF;
      end
      a_start = (cyc == start_at);
      if (cyc == 0) check("a_emit_first_gap", 32'(a_out_valid), 0);
      if (cyc == 1) check("a_emit_first_valid", 32'(a_out_valid), 1);
      if (a_out_valid) begin
        check("a_out_data", 32'(a_out_data), 32'(m[k % 4][k / 4]));
        check("a_out_i", 32'(a_out_i), 32'(k / 4));
        check("a_out_j", 32'(a_out_j), 32'(k % 4));
        check("a_out_last", 32'(a_out_last), 32'(k == 15));
        check("a_busy_emit", 32'(a_busy), 1);
        if (a_out_ready) k++;
      end
      @(negedge clk);
      cyc++;
    end
    a_in_valid = 1'b0;
    a_start    = 1'b0;
    check("a_emit_count", 32'(k), 16);
    check("a_done_pulse", 32'(a_done), 1);
    check("a_busy_done", 32'(a_busy), 0);
    check("a_valid_done", 32'(a_out_valid), 0);
    a_start = restart;
    @(negedge clk);
    a_start = 1'b0;
    check("a_done_single", 32'(a_done), 0);
    check("a_restart_ready", 32'(a_in_ready), 32'(restart));
  endtask

  task automatic rand_mat(output mat_t m);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) m[i][j] = 8'($urandom_range(0, 254));
  endtask

  initial begin
    mat_t m, m2;
    int k, g;
    a_start = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
    b_start = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 1;
    c_start = 0; c_in_valid = 0; c_in_data = 0; c_out_ready = 1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_a_reset("a_reset_vals");
    rst = 1'b0;
    @(negedge clk);

    // Illegal traffic in IDLE, then 0..15 with 1-0-0-1 backpressure.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) m[i][j] = 8'(i * 4 + j);
    a_in_valid = 1'b1;
    a_in_data  = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      check("a_idle_ready", 32'({a_in_ready, a_busy}), 0);
    end
    a_in_valid = 1'b0;
    start_a();
    load_a(m, 1'b0, -1);
    emit_a(m, 1, 1'b0, -1, 1'b0);

    // Random input gaps, 0xFF junk during EMIT, random backpressure.
    rand_mat(m);
    start_a();
    load_a(m, 1'b1, -1);
    emit_a(m, 2, 1'b1, -1, 1'b0);

    // Reset after 5 of 16 elements, then a fresh 0..15.
    rand_mat(m);
    start_a();
    load_a(m, 1'b0, 5);
    rst = 1'b1;
    #1;
    check_a_reset("a_reset_midload");
    a_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_a_reset("a_after_reset_idle");
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) m[i][j] = 8'(i * 4 + j);
    start_a();
    load_a(m, 1'b0, -1);
    emit_a(m, 0, 1'b0, -1, 1'b0);

    // Start mid-EMIT is ignored; start in the done cycle begins a second transpose.
    rand_mat(m);
    rand_mat(m2);
    start_a();
    load_a(m, 1'b0, -1);
    emit_a(m, 0, 1'b0, 6, 1'b1);
    load_a(m2, 1'b1, -1);
    emit_a(m2, 1, 1'b0, -1, 1'b0);

    // 2x3: 1..6 streamed back to back, output 1,4,2,5,3,6.
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    k = 0;
    g = 0;
    b_in_valid = 1'b1;
    while (k < 6 && g < 100) begin
      b_in_data = 8'(k + 1);
      if (b_in_ready) k++;
      @(negedge clk);
      g++;
    end
    b_in_valid = 1'b0;
    check("b_load_cycles", 32'(g), 6);
    g = 0;
    while (!b_out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("b_first_valid_wait", 32'(g), 1);
    for (int n = 0; n < 6; n++) begin
      check("b_out_valid", 32'(b_out_valid), 1);
      check("b_out_data", 32'(b_out_data), 32'((n % 2) * 3 + (n / 2) + 1));
      check("b_out_ij", 32'({b_out_i, b_out_j}), 32'({2'(n / 2), 1'(n % 2)}));
      check("b_out_last", 32'(b_out_last), 32'(n == 5));
      @(negedge clk);
    end
    check("b_done", 32'({b_done, b_busy, b_out_valid}), 32'(3'b100));
    @(negedge clk);
    check("b_done_single", 32'(b_done), 0);

    // 1x1: single element 0x5A.
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    c_in_valid = 1'b1;
    c_in_data  = 8'h5A;
    @(negedge clk);
    c_in_valid = 1'b0;
    check("c_ready_drop", 32'(c_in_ready), 0);
    g = 0;
    while (!c_out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("c_first_valid_wait", 32'(g), 1);
    check("c_out_data", 32'(c_out_data), 32'h5A);
    check("c_out_last_ij", 32'({c_out_last, c_out_i, c_out_j}), 32'(3'b100));
    @(negedge clk);
    check("c_done", 32'({c_done, c_busy, c_out_valid}), 32'(3'b100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
